riscv_dmem_responder: RTL and testbench



---
 rtl/riscv_dmem_responder.sv | 123 ++++++++++++
 tb/tb_riscv_dmem_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: wait-stated word memory behind request/response handshakes; RISCV_DMEM_MISALIGN_TRAP_EN faults misaligned addresses
module riscv_dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LOAD_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      r_state, w_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_rsp_valid, r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];
    logic        w_accept, w_do, w_we, w_oor, w_mis, w_err, w_wr;
    logic [31:0] w_addr, w_wdata;
    logic [3:0]  w_wstrb;
    logic [29:0] w_idx;

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign w_accept  = req_valid & req_ready;
    // With zero wait states the access uses the live request on the accept edge
    assign w_we      = req_ready ? req_we    : r_we;
    assign w_addr    = req_ready ? req_addr  : r_addr;
    assign w_wdata   = req_ready ? req_wdata : r_wdata;
    assign w_wstrb   = req_ready ? req_wstrb : r_wstrb;
    assign w_do      = !reset && ((w_accept && WAIT_CYCLES == 0) || (r_state == WAIT && r_cnt == 4'd0));
    assign w_idx     = w_addr[31:2];
    assign w_oor     = w_idx >= 30'(DEPTH_WORDS);
`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
    assign w_mis     = |w_addr[1:0];
`else
    assign w_mis     = 1'b0 & (|w_addr[1:0]);
`endif
    assign w_err     = w_oor | w_mis;
    assign w_wr      = w_do & w_we & ~w_err;

    // Next-state and wait-counter decode
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: if (w_accept) begin
                w_next     = (WAIT_CYCLES == 0) ? RESP : WAIT;
                w_cnt_next = LOAD_CNT;
            end
            WAIT: begin
                w_next     = (r_cnt == 4'd0) ? RESP : WAIT;
                w_cnt_next = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
            end
            RESP: w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture the request on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end
    end

    // Registered response: loaded on the access edge, cleared on handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else if (w_do) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (!w_we && !w_err) ? r_mem[w_idx[AW-1:0]] : 32'd0;
            r_rsp_err   <= w_err;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end
    end

    // Byte-masked store into the unreset array
    always_ff @(posedge clk) begin
        if (w_wr)
            for (int i = 0; i < 4; i++)
                if (w_wstrb[i]) r_mem[w_idx[AW-1:0]][8*i +: 8] <= w_wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb_riscv_dmem_responder: table-driven and sequenced checks of the data-memory responder
module tb_riscv_dmem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    int          pass_cnt = 0;
    int          total_cnt = 0;

`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif
    localparam int WC = 2;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[21];

    riscv_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Issue one request with rsp_ready high; returns response and observed latency
    task automatic run_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] s, output logic [31:0] rd, output logic er,
                           output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = s;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic do_vec(input string nm, input vec_t v);
        logic [31:0] rd;
        logic        er;
        int          lat;
        run_req(v.we, v.addr, v.wdata, v.wstrb, rd, er, lat);
        check({nm, "_lat"}, 32'(lat), 32'(WC));
        check({nm, "_rdata"}, rd, v.exp_rdata);
        check({nm, "_err"}, {31'd0, er}, {31'd0, v.exp_err});
        @(negedge clk);
        check({nm, "_idle"}, {29'd0, req_ready, rsp_valid, rsp_err}, 32'b100);
        check({nm, "_clr"}, rsp_rdata, 32'd0);
    endtask

    initial begin
        logic [31:0] bp_exp;
        int          lat;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h10,  32'h11223344, 4'h5, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[4]  = '{1'b0, 32'h400, 32'h0,        4'h0, 32'h0, 1'b1};
        vecs[5]  = '{1'b1, 32'h0,   32'h01020304, 4'hF, 32'h0, 1'b0};
        vecs[6]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h01020304, 1'b0};
        vecs[8]  = '{1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
        vecs[10] = '{1'b1, 32'h14,  32'h55667788, 4'hF, 32'h0, 1'b0};
        vecs[11] = '{1'b1, 32'h14,  32'h12345678, 4'h0, 32'h0, 1'b0};
        vecs[12] = '{1'b0, 32'h14,  32'h0,        4'h0, 32'h55667788, 1'b0};
        vecs[13] = '{1'b1, 32'h12,  32'h99999999, 4'hF, 32'h0, MIS};
        vecs[14] = '{1'b0, 32'h10,  32'h0,        4'h0, MIS ? 32'hDE22BE44 : 32'h99999999, 1'b0};
        vecs[15] = '{1'b1, 32'h20,  32'h11111111, 4'hF, 32'h0, 1'b0};
        vecs[16] = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11111111, 1'b0};
        vecs[17] = '{1'b0, 32'h13,  32'h0,        4'h0, MIS ? 32'h0 : 32'h99999999, MIS};
        vecs[18] = '{1'b1, 32'h0,   32'hAABBCCDD, 4'hA, 32'h0, 1'b0};
        vecs[19] = '{1'b0, 32'h0,   32'h0,        4'h0, 32'hAA02CC04, 1'b0};
        vecs[20] = '{1'b0, 32'hFFFFFFFC, 32'h0,   4'h0, 32'h0, 1'b1};
        bp_exp = MIS ? 32'hDE22BE44 : 32'h99999999;

        repeat (2) @(negedge clk);
        check("rst_hold_flags", {29'd0, req_ready, rsp_valid, rsp_err}, 32'b100);
        check("rst_hold_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("rst_idle%0d_flags", i), {29'd0, req_ready, rsp_valid, rsp_err}, 32'b100);
            check($sformatf("rst_idle%0d_rdata", i), rsp_rdata, 32'd0);
        end

        for (int i = 0; i < 21; i++) do_vec($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: hold the response while a stray store request is offered
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wstrb = 4'h0; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp_lat", 32'(lat), 32'(WC));
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_wstrb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d_flags", i), {29'd0, req_ready, rsp_valid, rsp_err}, 32'b010);
            check($sformatf("bp%0d_rdata", i), rsp_rdata, bp_exp);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {29'd0, req_ready, rsp_valid, rsp_err}, 32'b100);
        do_vec("bp_after", '{1'b0, 32'h10, 32'h0, 4'h0, bp_exp, 1'b0});

        // Reset during WAIT drops the pending store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_flags", {29'd0, req_ready, rsp_valid, rsp_err}, 32'b100);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("midrst_idle%0d", i), {29'd0, req_ready, rsp_valid, rsp_err}, 32'b100);
        end
        do_vec("midrst_load", '{1'b0, 32'h20, 32'h0, 4'h0, 32'h11111111, 1'b0});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
